// File: rtl/gray_code_pkg.sv
// Shared types and Gray/binary helpers for the Gray-code counter.
package gray_code_pkg;

    localparam int GRAY_W_DEFAULT = 3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Inverse conversion, kept here for checkers that decode the output.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_code_conv.sv
// Purely combinational binary-to-Gray conversion.
module gray_code_conv #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_code_counter_top.sv
// Free-running up/down Gray-code counter with a registered output.
// Optional simulation checks are compiled in when GRAY_CNT_ASSERT_EN is defined.
module gray_code_counter_top
    import gray_code_pkg::*;
#(
    parameter int WIDTH = GRAY_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rstN,
    input  logic             dir,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;

    always_comb begin
        bin_next = bin + WIDTH'(1);
        if (dir_e'(dir) == DIR_DOWN) begin
            bin_next = bin - WIDTH'(1);
        end
    end

    gray_code_conv #(.WIDTH(WIDTH)) u_conv (
        .bin  (bin_next),
        .gray (gray_next)
    );

    // Both registers load on the same edge so out always tracks gray(bin).
    always_ff @(posedge clk) begin
        if (rst || !rstN) begin
            bin <= '0;
            out <= '0;
        end else begin
            bin <= bin_next;
            out <= gray_next;
        end
    end

`ifdef GRAY_CNT_ASSERT_EN
    a_one_bit_step: assert property (@(posedge clk)
        $past(!rst && rstN) |-> ($countones(out ^ $past(out)) == 1))
        else $error("gray counter changed more than one bit: %b -> %b", $past(out), out);

    a_out_matches_bin: assert property (@(posedge clk)
        out == WIDTH'(bin2gray(32'(bin))))
        else $error("gray counter out %b does not match bin %b", out, bin);
`endif

endmodule

// File: tb/tb_gray_code_counter_top.sv
// Directed bench for gray_code_counter_top at the default 3-bit width.
module tb_gray_code_counter_top;

    logic       clk;
    logic       rst;
    logic       rstN;
    logic       dir;
    logic [2:0] out;
    logic [2:0] prev;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] UP_SEQ[8]   = '{3'b001, 3'b011, 3'b010, 3'b110,
                                           3'b111, 3'b101, 3'b100, 3'b000};
    localparam logic [2:0] DOWN_SEQ[8] = '{3'b100, 3'b101, 3'b111, 3'b110,
                                           3'b010, 3'b011, 3'b001, 3'b000};

    gray_code_counter_top #(.WIDTH(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .rstN (rstN),
        .dir  (dir),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic rn, input logic d,
                        input logic [2:0] exp, input string tag);
        rst  = r;
        rstN = rn;
        dir  = d;
        @(posedge clk);
        @(negedge clk);
        checks++;
        assert (out === exp) else begin
            failures++;
            $error("FAIL %s: out=%b expected=%b", tag, out, exp);
        end
        if (!r && rn) begin
            checks++;
            assert ($countones(out ^ prev) == 1) else begin
                failures++;
                $error("FAIL %s_onebit: prev=%b out=%b expected one bit change", tag, prev, out);
            end
        end
        prev = out;
    endtask

    initial begin
        rst  = 1'b1;
        rstN = 1'b1;
        dir  = 1'b0;
        prev = 3'b000;

        step(1'b1, 1'b1, 1'b0, 3'b000, "reset");

        // Up count over two full laps: back at 000 after edges 8 and 16.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, UP_SEQ[i % 8], $sformatf("up_%0d", i + 1));
        end

        step(1'b1, 1'b1, 1'b0, 3'b000, "reset_down");
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, DOWN_SEQ[i], $sformatf("down_%0d", i + 1));
        end

        step(1'b1, 1'b1, 1'b0, 3'b000, "reset_rev");
        step(1'b0, 1'b1, 1'b0, 3'b001, "rev_up1");
        step(1'b0, 1'b1, 1'b0, 3'b011, "rev_up2");
        step(1'b0, 1'b1, 1'b0, 3'b010, "rev_up3");
        step(1'b0, 1'b1, 1'b1, 3'b011, "rev_down1");
        step(1'b0, 1'b1, 1'b1, 3'b001, "rev_down2");

        step(1'b1, 1'b1, 1'b0, 3'b000, "reset_clr");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0, UP_SEQ[i], $sformatf("clr_up_%0d", i + 1));
        end
        step(1'b0, 1'b0, 1'b1, 3'b000, "soft_clear");
        step(1'b0, 1'b1, 1'b0, 3'b001, "clr_release");

        step(1'b0, 1'b1, 1'b0, 3'b011, "pri_up1");
        step(1'b0, 1'b1, 1'b0, 3'b010, "pri_up2");
        step(1'b0, 1'b1, 1'b0, 3'b110, "pri_up3");
        step(1'b1, 1'b0, 1'b1, 3'b000, "priority");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 3'b000, $sformatf("rst_hold_%0d", i + 1));
        end
        step(1'b0, 1'b1, 1'b1, 3'b100, "release_down");
        step(1'b0, 1'b1, 1'b1, 3'b101, "release_down2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_code_counter_top.md
Name: gray_code_counter_top

Overview:
Free-running up/down Gray-code counter with a registered WIDTH-bit output (default 3 bits). It is a standalone sequencing block. Typical uses are glitch-safe state indices and pointers handed to logic that samples them asynchronously. Internally it keeps a binary count register and a registered binary-to-Gray conversion.

Parameters:
- WIDTH, 3, counter and output width in bits (≥2); count modulus is 2^WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; highest priority.
- rstN  input  1  synchronous, active-low soft clear. 0 clears the count exactly as rst does; 1 allows counting.
- dir  input  1  count direction: 0 = up, 1 = down; sampled every rising edge.
- out  output  WIDTH  current count in Gray code; driven directly from a flop.

Behaviour:
- Internal state: binary count register bin[WIDTH-1:0] and output register out[WIDTH-1:0].
- Reset:
  - rst=1 at a rising edge → bin=0 and out=0 (000) after that edge.
  - rst has priority over rstN and dir.
  - While rst is held high, out stays 000.
- Soft clear: rst=0 and rstN=0 at an edge → bin=0, out=000, identical to reset. dir is ignored.
- Counting applies when rst=0 and rstN=1:
  - dir=0: bin_next = bin+1, mod 2^WIDTH.
  - dir=1: bin_next = bin−1, mod 2^WIDTH.
  - out_next = bin_next ^ (bin_next >> 1).
  - bin and out update on the same edge, so out always equals gray(bin).
- Latency: an input change seen at edge N is reflected in out after edge N. There is no combinational path from any input to out.
- Up sequence (WIDTH=3): 000→001→011→010→110→111→101→100→000 (wraps).
- Down sequence (WIDTH=3): reverse order; 000→100 on underflow.
- Wrap-around: there is no terminal hold.
  - Up: 100 → 000.
  - Down: 000 → 100.
- Direction change:
  - Takes effect at the next edge, with no skipped or repeated code.
  - Example: at 011, toggling dir to 1 gives 001 next.
- One-bit property: every counting transition changes exactly one bit of out. Only reset/soft clear may change more than one bit.
- Release from reset: the first edge with rst=0, rstN=1 advances from 000 (to 001 if dir=0, to 100 if dir=1).
- Reset mid-count: any state returns to 000 on the edge where rst (or !rstN) is sampled.
- Inputs are assumed synchronous to clk; no internal synchronizers.

Optional Feature:
- Macro GRAY_CNT_ASSERT_EN.
- Defined:
  - Compiles in simulation-only concurrent assertions.
  - Checks that outside reset/clear, $countones(out ^ $past(out)) == 1.
  - Checks that out == gray(bin) on every cycle.
  - A failure reports via $error.
- Undefined: no assertion code; the synthesized logic is identical either way.

Decomposition:
- Package gray_code_pkg:
  - Constant GRAY_W_DEFAULT = 3.
  - Enum typedef dir_e {DIR_UP=1'b0, DIR_DOWN=1'b1}.
  - Functions bin2gray(), and gray2bin() for checkers.
- Sub-module: gray_code_conv. Purely combinational binary-to-Gray conversion, parameterized by WIDTH, instantiated once on bin_next.
- Top holds the binary counter, the reset/clear priority and the output register.

Test Plan:
- Reset: rst=1 for one 10 ns cycle, rstN=1, dir=0 → out=000 during reset. After release, successive edges give 001, 011, 010, 110, 111, 101, 100, 000.
- Down count: dir=1 from reset → 100, 101, 111, 110, 010, 011, 001, 000.
- Direction reversal: count up to 010, set dir=1 → next 011, then 001. Each step changes exactly one bit.
- Soft clear: at 111, drive rstN=0 for one edge → out=000. Restore rstN=1 → out=001 at the next edge (dir=0).
- Priority: rst=1 with rstN=0 and dir=1 at state 110 → out=000. Holding rst=1 for 5 cycles keeps out=000.
- Wrap: run 16 up-count edges from 000 → out back at 000 after edges 8 and 16. With GRAY_CNT_ASSERT_EN defined, no assertion fires.
